ds_operand_stage: RTL

//  Parametrised decode-stage front end for the LoongArch 5-stage pipeline.
//  - Holds the fs->ds pipeline register and the 2R1W architectural register file.
//  - Resolves two source operands with forwarding from N_FWD later stages.
//  - Interlocks on sources that are not yet produced (load-use, multicycle div).
//  - Supports flush and counts stall cycles. Opcode decode sits outside: it

---
 rtl/ds_operand_stage_pkg.sv | 17 +
 rtl/ds_operand_stage_regfile_2r1w.sv | 40 ++++
 rtl/ds_operand_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ds_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ds_operand_stage_pkg
// Desc     : Shared widths for the decode-stage operand front end.
// Revision : 1.0 - initial release
// ============================================================================
package ds_operand_stage_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_AW       = 5;
    localparam int NUM_REGS     = 32;
    localparam int INST_W       = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : ds_operand_stage_pkg
`default_nettype wire

// File: rtl/ds_operand_stage_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Desc     : 32-entry 2R1W register file, r0 hard-zero, write-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w
    import ds_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  reg_addr_t       raddr1,
    input  reg_addr_t       raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  reg_addr_t       waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] r_mem [NUM_REGS];
    logic            w_wr_en;

    assign w_wr_en = we && (waddr != '0);

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0)                 ? '0    :
                    (w_wr_en && waddr == raddr1)   ? wdata : r_mem[raddr1];
    assign rdata2 = (raddr2 == '0)                 ? '0    :
                    (w_wr_en && waddr == raddr2)   ? wdata : r_mem[raddr2];

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/ds_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ds_operand_stage
// Desc     : Decode-stage pipeline register, operand forwarding and interlock.
// Revision : 1.0 - initial release
// ============================================================================
module ds_operand_stage
    import ds_operand_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int N_FWD = 3,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fs_to_ds_valid,
    input  logic [INST_W-1:0]       fs_inst,
    input  logic [XLEN-1:0]         fs_pc,
    output logic                    ds_allowin,
    input  logic                    es_allowin,
    output logic                    ds_to_es_valid,
    input  logic                    flush,
    output logic [INST_W-1:0]       ds_inst,
    output logic [XLEN-1:0]         ds_pc,
    input  logic [REG_AW-1:0]       src1_addr,
    input  logic                    src1_used,
    input  logic [REG_AW-1:0]       src2_addr,
    input  logic                    src2_used,
    output logic [XLEN-1:0]         src1_data,
    output logic [XLEN-1:0]         src2_data,
    input  logic [N_FWD-1:0]        fwd_valid,
    input  logic [REG_AW*N_FWD-1:0] fwd_waddr,
    input  logic [N_FWD-1:0]        fwd_data_ok,
    input  logic [XLEN*N_FWD-1:0]   fwd_wdata,
    input  logic                    rf_we,
    input  logic [REG_AW-1:0]       rf_waddr,
    input  logic [XLEN-1:0]         rf_wdata,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic                    r_ds_valid;
    logic [INST_W-1:0]       r_ds_inst;
    logic [XLEN-1:0]         r_ds_pc;
    logic [CNT_W-1:0]        r_stall_cnt;

    logic                    w_ready_go;
    logic [1:0]              w_hazard;
    logic [1:0][REG_AW-1:0]  w_src_addr;
    logic [1:0]              w_src_used;
    logic [1:0][XLEN-1:0]    w_rf_rdata;
    logic [1:0][XLEN-1:0]    w_src_data;

    assign w_src_addr = {src2_addr, src1_addr};
    assign w_src_used = {src2_used, src1_used};

    regfile_2r1w #(
        .XLEN   (XLEN)
    ) u_regfile (
        .clk    (clk),
        .raddr1 (src1_addr),
        .raddr2 (src2_addr),
        .rdata1 (w_rf_rdata[0]),
        .rdata2 (w_rf_rdata[1]),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic            w_hit;
        logic            w_ok;
        logic [XLEN-1:0] w_fwd;

        // Scan oldest to youngest so the youngest match overwrites older ones.
        always_comb begin
            w_hit = 1'b0;
            w_ok  = 1'b0;
            w_fwd = '0;
            for (int i = N_FWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && (fwd_waddr[REG_AW*i +: REG_AW] == w_src_addr[s])) begin
                    w_hit = 1'b1;
                    w_ok  = fwd_data_ok[i];
                    w_fwd = fwd_wdata[XLEN*i +: XLEN];
                end
            end
        end

        assign w_hazard[s]   = w_src_used[s] && (w_src_addr[s] != '0) && w_hit && !w_ok;
        assign w_src_data[s] = (w_src_addr[s] == '0) ? '0    :
                               w_hit                 ? w_fwd : w_rf_rdata[s];
    end

    assign w_ready_go     = ~(|w_hazard);
    assign ds_allowin     = ~r_ds_valid | (w_ready_go & es_allowin);
    assign ds_to_es_valid = r_ds_valid & w_ready_go & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ds_valid  <= 1'b0;
            r_ds_inst   <= '0;
            r_ds_pc     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_ds_valid <= 1'b0;
            end else if (ds_allowin) begin
                r_ds_valid <= fs_to_ds_valid;
            end
            if (fs_to_ds_valid && ds_allowin && !flush) begin
                r_ds_inst <= fs_inst;
                r_ds_pc   <= fs_pc;
            end
            if (r_ds_valid && !w_ready_go && !flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign ds_inst   = r_ds_inst;
    assign ds_pc     = r_ds_pc;
    assign stall_cnt = r_stall_cnt;
    assign src1_data = w_src_data[0];
    assign src2_data = w_src_data[1];

endmodule : ds_operand_stage
`default_nettype wire
